traffic_light_monitor: RTL and testbench

Passive checker on the receiving end of a two-way junction light bus. Each cycle it samples the two 3-bit light vectors driven by the junction controller, decodes them into phases, and checks the following:
- legal light codes
- legal phase sequence
- mutual exclusion (at least one side red)
- alternation fairness between sides
- maximum dwell time in each phase

Violations raise sticky error flags and capture the first failure. It sits beside the light controller in the junction subsystem and feeds the fault/status logic.

---
 rtl/traffic_light_monitor.sv | 182 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-way junction light bus: decodes both sides and flags illegal
// codes, sequence, conflict, fairness and dwell violations. Define TRAFFIC_LIGHT_MONITOR_COUNT_EN for cycle counters.
module traffic_light_monitor #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lights_a,
  input  logic [2:0]       lights_b,
  input  logic             clr,
  output logic [1:0]       phase_a,
  output logic [1:0]       phase_b,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_conflict,
  output logic             err_fair,
  output logic             err_stall,
  output logic             err_any,
`ifdef TRAFFIC_LIGHT_MONITOR_COUNT_EN
  output logic [5:0]       first_err,
  output logic [CNT_W-1:0] cycles_a,
  output logic [CNT_W-1:0] cycles_b
`else
  output logic [5:0]       first_err
`endif
);

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RA = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_A  = 2'd3;

  localparam int HOLD_W = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    T_UNKNOWN = 2'd0,
    T_A       = 2'd1,
    T_B       = 2'd2
  } turn_t;

  function automatic logic code_legal(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b110) || (c == 3'b001) || (c == 3'b010);
  endfunction

  function automatic logic [1:0] code_phase(input logic [2:0] c);
    case (c)
      3'b110:  return PH_RA;
      3'b001:  return PH_G;
      3'b010:  return PH_A;
      default: return PH_R;
    endcase
  endfunction

  // Phase encoding is ordered so every legal move is "hold" or "+1 modulo 4".
  function automatic logic step_ok(input logic [1:0] prev, input logic [1:0] cur);
    return (cur == prev) || (cur == prev + 2'd1);
  endfunction

  function automatic logic [HOLD_W-1:0] hold_step(input logic [HOLD_W-1:0] cnt,
                                                  input logic legal, input logic pv,
                                                  input logic [1:0] prev, input logic [1:0] cur);
    if (!legal || cur == PH_R) return '0;
    if (!pv || cur != prev) return HOLD_W'(1);
    if (cnt >= HOLD_SAT) return HOLD_SAT;
    return cnt + HOLD_W'(1);
  endfunction

  logic              pv_a, pv_b;
  logic [HOLD_W-1:0] hold_a, hold_b;
  turn_t             turn;

  logic              legal_a_p0, legal_b_p0;
  logic [1:0]        dec_a_p0, dec_b_p0;
  logic              red_a_p0, red_b_p0;
  logic              start_a_p0, start_b_p0;
  logic              done_a_p0, done_b_p0;
  logic [HOLD_W-1:0] hold_a_nxt_p0, hold_b_nxt_p0;
  logic              code_hit_p0, seq_hit_p0, conflict_hit_p0, fair_hit_p0, stall_hit_p0;
  logic              any_hit_p0;
  logic              code_nxt_p0, seq_nxt_p0, conflict_nxt_p0, fair_nxt_p0, stall_nxt_p0;

  // Decode and violation detection on the current sample
  assign legal_a_p0 = code_legal(lights_a);
  assign legal_b_p0 = code_legal(lights_b);
  assign dec_a_p0   = code_phase(lights_a);
  assign dec_b_p0   = code_phase(lights_b);
  assign red_a_p0   = legal_a_p0 && (dec_a_p0 == PH_R);
  assign red_b_p0   = legal_b_p0 && (dec_b_p0 == PH_R);

  assign start_a_p0 = legal_a_p0 && pv_a && (phase_a == PH_R) && (dec_a_p0 == PH_RA);
  assign start_b_p0 = legal_b_p0 && pv_b && (phase_b == PH_R) && (dec_b_p0 == PH_RA);
  assign done_a_p0  = legal_a_p0 && pv_a && (phase_a == PH_A) && (dec_a_p0 == PH_R);
  assign done_b_p0  = legal_b_p0 && pv_b && (phase_b == PH_A) && (dec_b_p0 == PH_R);

  assign hold_a_nxt_p0 = hold_step(hold_a, legal_a_p0, pv_a, phase_a, dec_a_p0);
  assign hold_b_nxt_p0 = hold_step(hold_b, legal_b_p0, pv_b, phase_b, dec_b_p0);

  assign code_hit_p0     = !legal_a_p0 || !legal_b_p0;
  assign seq_hit_p0      = (legal_a_p0 && pv_a && !step_ok(phase_a, dec_a_p0)) ||
                           (legal_b_p0 && pv_b && !step_ok(phase_b, dec_b_p0));
  assign conflict_hit_p0 = !red_a_p0 && !red_b_p0;
  assign fair_hit_p0     = (start_a_p0 && start_b_p0) ||
                           ((turn == T_A) && start_a_p0) ||
                           ((turn == T_B) && start_b_p0);
  assign stall_hit_p0    = (hold_a_nxt_p0 > HOLD_LIM) || (hold_b_nxt_p0 > HOLD_LIM);
  assign any_hit_p0      = code_hit_p0 || seq_hit_p0 || conflict_hit_p0 ||
                           fair_hit_p0 || stall_hit_p0;

  // A clear in the same cycle as a fresh violation still leaves that flag set
  assign code_nxt_p0     = (err_code     && !clr) || code_hit_p0;
  assign seq_nxt_p0      = (err_seq      && !clr) || seq_hit_p0;
  assign conflict_nxt_p0 = (err_conflict && !clr) || conflict_hit_p0;
  assign fair_nxt_p0     = (err_fair     && !clr) || fair_hit_p0;
  assign stall_nxt_p0    = (err_stall    && !clr) || stall_hit_p0;

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_a      <= PH_R;
      phase_b      <= PH_R;
      pv_a         <= 1'b0;
      pv_b         <= 1'b0;
      hold_a       <= '0;
      hold_b       <= '0;
      turn         <= T_UNKNOWN;
      err_code     <= 1'b0;
      err_seq      <= 1'b0;
      err_conflict <= 1'b0;
      err_fair     <= 1'b0;
      err_stall    <= 1'b0;
      err_any      <= 1'b0;
      first_err    <= '0;
    end else begin
      if (legal_a_p0) phase_a <= dec_a_p0;
      if (legal_b_p0) phase_b <= dec_b_p0;
      pv_a   <= legal_a_p0;
      pv_b   <= legal_b_p0;
      hold_a <= hold_a_nxt_p0;
      hold_b <= hold_b_nxt_p0;

      // Simultaneous starts leave the turn where it was
      if (start_a_p0 && !start_b_p0)      turn <= T_A;
      else if (start_b_p0 && !start_a_p0) turn <= T_B;

      err_code     <= code_nxt_p0;
      err_seq      <= seq_nxt_p0;
      err_conflict <= conflict_nxt_p0;
      err_fair     <= fair_nxt_p0;
      err_stall    <= stall_nxt_p0;
      err_any      <= code_nxt_p0 || seq_nxt_p0 || conflict_nxt_p0 ||
                      fair_nxt_p0 || stall_nxt_p0;

      if (any_hit_p0 && (!err_any || clr)) first_err <= {lights_a, lights_b};
      else if (clr)                        first_err <= '0;
    end
  end

`ifdef TRAFFIC_LIGHT_MONITOR_COUNT_EN
  // Completed-cycle counters, one per A->R transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_a <= '0;
      cycles_b <= '0;
    end else if (clr) begin
      cycles_a <= '0;
      cycles_b <= '0;
    end else begin
      cycles_a <= cycles_a + CNT_W'(done_a_p0);
      cycles_b <= cycles_b + CNT_W'(done_b_p0);
    end
  end
`else
  logic             unused_done;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_done = done_a_p0 ^ done_b_p0;
  assign unused_cnt  = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default MAX_HOLD = 8).
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst_n;
  logic [2:0] lights_a;
  logic [2:0] lights_b;
  logic       clr;
  logic [1:0] phase_a;
  logic [1:0] phase_b;
  logic       err_code;
  logic       err_seq;
  logic       err_conflict;
  logic       err_fair;
  logic       err_stall;
  logic       err_any;
  logic [5:0] first_err;
`ifdef TRAFFIC_LIGHT_MONITOR_COUNT_EN
  logic [7:0] cycles_a;
  logic [7:0] cycles_b;
`endif

  int checks = 0;
  int errors = 0;

  traffic_light_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lights_a     (lights_a),
    .lights_b     (lights_b),
    .clr          (clr),
    .phase_a      (phase_a),
    .phase_b      (phase_b),
    .err_code     (err_code),
    .err_seq      (err_seq),
    .err_conflict (err_conflict),
    .err_fair     (err_fair),
    .err_stall    (err_stall),
    .err_any      (err_any),
`ifdef TRAFFIC_LIGHT_MONITOR_COUNT_EN
    .first_err    (first_err),
    .cycles_a     (cycles_a),
    .cycles_b     (cycles_b)
`else
    .first_err    (first_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at the falling edge; return 1 time unit after the sampling edge.
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c);
    @(negedge clk);
    lights_a = a;
    lights_b = b;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    lights_a = 3'b100;
    lights_b = 3'b100;
    clr      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    lights_a = 3'b100;
    lights_b = 3'b100;
    clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({phase_a, phase_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_phase got %b want 0000", {phase_a, phase_b});
    end
    checks++;
    if ({err_code, err_seq, err_conflict, err_fair, err_stall, err_any} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {err_code, err_seq, err_conflict, err_fair, err_stall, err_any});
    end
    checks++;
    if (first_err !== 6'b0) begin
      errors++; $display("FAIL reset_first_err got %b want 000000", first_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [2:0] codes [4];
    logic [1:0] exp_ph [4];
    codes  = '{3'b110, 3'b001, 3'b010, 3'b100};
    exp_ph = '{2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(3'b100, codes[i], 1'b0);
        checks++;
        if (phase_b !== exp_ph[i]) begin
          errors++; $display("FAIL nominal_phase_b round %0d step %0d got %0d want %0d", r, i, phase_b, exp_ph[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        drive(codes[i], 3'b100, 1'b0);
        checks++;
        if (phase_a !== exp_ph[i]) begin
          errors++; $display("FAIL nominal_phase_a round %0d step %0d got %0d want %0d", r, i, phase_a, exp_ph[i]);
        end
      end
    end
    checks++;
    if ({err_code, err_seq, err_conflict, err_fair, err_stall, err_any} !== 6'b0) begin
      errors++;
      $display("FAIL nominal_flags got %b want 000000",
               {err_code, err_seq, err_conflict, err_fair, err_stall, err_any});
    end
`ifdef TRAFFIC_LIGHT_MONITOR_COUNT_EN
    checks++;
    if (cycles_a !== 8'd4 || cycles_b !== 8'd4) begin
      errors++; $display("FAIL nominal_cycles got a=%0d b=%0d want 4 4", cycles_a, cycles_b);
    end
`endif
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b110, 3'b100, 1'b0);
    drive(3'b001, 3'b100, 1'b0);
    drive(3'b111, 3'b100, 1'b0);
    checks++;
    if (err_code !== 1'b1) begin
      errors++; $display("FAIL illegal_err_code got %b want 1", err_code);
    end
    checks++;
    if (first_err !== 6'b111100) begin
      errors++; $display("FAIL illegal_first_err got %b want 111100", first_err);
    end
    checks++;
    if (phase_a !== 2'd2) begin
      errors++; $display("FAIL illegal_phase_hold got %0d want 2", phase_a);
    end
    checks++;
    if (err_conflict !== 1'b0) begin
      errors++; $display("FAIL illegal_no_conflict got %b want 0", err_conflict);
    end
    // G -> R would be illegal, but the sample after a bad code is not sequence checked
    drive(3'b100, 3'b100, 1'b0);
    checks++;
    if (err_seq !== 1'b0 || phase_a !== 2'd0) begin
      errors++; $display("FAIL illegal_recover got seq=%b phase_a=%0d want 0 0", err_seq, phase_a);
    end
  endtask

  task automatic test_seq_conflict();
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b100, 3'b001, 1'b0);
    checks++;
    if (err_seq !== 1'b1 || err_conflict !== 1'b0) begin
      errors++; $display("FAIL seq_bad got seq=%b conflict=%b want 1 0", err_seq, err_conflict);
    end
    checks++;
    if (first_err !== 6'b100001) begin
      errors++; $display("FAIL seq_first_err got %b want 100001", first_err);
    end
    drive(3'b001, 3'b001, 1'b0);
    checks++;
    if (err_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_flag got %b want 1", err_conflict);
    end
    checks++;
    if (first_err !== 6'b100001) begin
      errors++; $display("FAIL conflict_first_err got %b want 100001", first_err);
    end
  endtask

  task automatic test_fair();
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b110, 3'b100, 1'b0);
    drive(3'b001, 3'b100, 1'b0);
    drive(3'b010, 3'b100, 1'b0);
    drive(3'b100, 3'b100, 1'b0);
    checks++;
    if (err_fair !== 1'b0) begin
      errors++; $display("FAIL fair_first_cycle got %b want 0", err_fair);
    end
    drive(3'b110, 3'b100, 1'b0);
    checks++;
    if (err_fair !== 1'b1) begin
      errors++; $display("FAIL fair_restart got %b want 1", err_fair);
    end
    checks++;
    if ({err_code, err_seq, err_conflict, err_stall} !== 4'b0) begin
      errors++; $display("FAIL fair_others got %b want 0000", {err_code, err_seq, err_conflict, err_stall});
    end
    checks++;
    if (first_err !== 6'b110100) begin
      errors++; $display("FAIL fair_first_err got %b want 110100", first_err);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b100, 3'b110, 1'b0);
    for (int i = 0; i < 8; i++) drive(3'b100, 3'b001, 1'b0);
    drive(3'b100, 3'b010, 1'b0);
    drive(3'b100, 3'b100, 1'b0);
    checks++;
    if (err_stall !== 1'b0 || err_any !== 1'b0) begin
      errors++; $display("FAIL stall_8_cycles got stall=%b any=%b want 0 0", err_stall, err_any);
    end
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b100, 3'b110, 1'b0);
    for (int i = 0; i < 8; i++) drive(3'b100, 3'b001, 1'b0);
    checks++;
    if (err_stall !== 1'b0) begin
      errors++; $display("FAIL stall_before_limit got %b want 0", err_stall);
    end
    drive(3'b100, 3'b001, 1'b0);
    checks++;
    if (err_stall !== 1'b1 || err_any !== 1'b1) begin
      errors++; $display("FAIL stall_9_cycles got stall=%b any=%b want 1 1", err_stall, err_any);
    end
    checks++;
    if (first_err !== 6'b100001) begin
      errors++; $display("FAIL stall_first_err got %b want 100001", first_err);
    end
  endtask

  task automatic test_clear_reset();
    apply_reset();
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b111, 3'b100, 1'b0);
    checks++;
    if (err_code !== 1'b1) begin
      errors++; $display("FAIL clear_setup got %b want 1", err_code);
    end
    drive(3'b100, 3'b100, 1'b1);
    checks++;
    if (err_code !== 1'b0 || err_any !== 1'b0 || first_err !== 6'b0) begin
      errors++; $display("FAIL clear_pulse got code=%b any=%b first=%b want 0 0 000000", err_code, err_any, first_err);
    end
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b111, 3'b100, 1'b0);
    drive(3'b001, 3'b001, 1'b1);
    checks++;
    if (err_conflict !== 1'b1 || err_code !== 1'b0 || err_seq !== 1'b1) begin
      errors++; $display("FAIL clear_with_error got conflict=%b code=%b seq=%b want 1 0 1", err_conflict, err_code, err_seq);
    end
    checks++;
    if (first_err !== 6'b001001) begin
      errors++; $display("FAIL clear_recapture got %b want 001001", first_err);
    end
    checks++;
    if (phase_a !== 2'd2 || phase_b !== 2'd2) begin
      errors++; $display("FAIL clear_phases got a=%0d b=%0d want 2 2", phase_a, phase_b);
    end
    // Asynchronous reset between clock edges
    clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phase_a, phase_b} !== 4'b0 || err_any !== 1'b0 || err_conflict !== 1'b0 || first_err !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got phases=%b any=%b conflict=%b first=%b want 0",
               {phase_a, phase_b}, err_any, err_conflict, first_err);
    end
    @(negedge clk);
    lights_a = 3'b100;
    lights_b = 3'b100;
    rst_n    = 1'b1;
    drive(3'b100, 3'b100, 1'b0);
    checks++;
    if (err_any !== 1'b0) begin
      errors++; $display("FAIL after_reset got %b want 0", err_any);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_illegal();
    test_seq_conflict();
    test_fair();
    test_stall();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
